// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] START_ADDR = 32'h8002_0000;

  localparam logic [1:0] ACC_1W  = 2'b00;
  localparam logic [1:0] ACC_4W  = 2'b01;
  localparam logic [1:0] ACC_8W  = 2'b10;
  localparam logic [1:0] ACC_16W = 2'b11;

  typedef enum logic {
    ISSUE     = 1'b0,
    WAIT_RESP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Request/response bus between the fetch stage (master) and memory (slave).
interface fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [1:0]            mem_access_size;
  logic                  mem_rw;
  logic                  mem_enable;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport master (
    output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    input  mem_busy, mem_data_out
  );

  modport slave (
    input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
    output mem_busy, mem_data_out
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, insn} pairs for the decode stage.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (!do_push && do_pop) count <= count - (PW+1)'(1);
    end
  end

  // Upstream credit accounting must make this unreachable.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one word read at a time, queues results.
//   state     | meaning
//   ISSUE     | may issue a read at pc when credit allows
//   WAIT_RESP | one read outstanding at req_pc, waiting for !mem_busy
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = fetch_pkg::START_ADDR,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  fetch_if.master               mem,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc
);

  import fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  kill;
  logic                  credit;
  logic                  issue;
  logic                  push;
  logic [CW:0]           fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign credit = (int'(fifo_count) + ((state == WAIT_RESP) ? 1 : 0)) < FIFO_DEPTH;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ISSUE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE:     if (issue) state_nxt = WAIT_RESP;
      WAIT_RESP: if (!mem.mem_busy) state_nxt = ISSUE;
      default:   state_nxt = ISSUE;
    endcase
  end

  // reset_n gates the strobe so nothing is requested while reset is held.
  always_comb begin
    issue           = 1'b0;
    push            = 1'b0;
    mem.mem_address = pc;
    case (state)
      ISSUE: issue = reset_n && credit && !mem.mem_busy && !redirect_valid;
      WAIT_RESP: begin
        mem.mem_address = req_pc;
        push            = !mem.mem_busy && !kill && !redirect_valid;
      end
      default: ;
    endcase
  end

  assign mem.mem_enable      = issue;
  assign mem.mem_data_in     = '0;
  assign mem.mem_access_size = ACC_1W;
  assign mem.mem_rw          = 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= START_ADDR;
      req_pc <= START_ADDR;
      kill   <= 1'b0;
    end else begin
      if (redirect_valid) pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (issue)     pc <= pc + ADDR_WIDTH'(4);
      if (issue) req_pc <= pc;
      // A redirect while a read is in flight marks its response as stale.
      if (state == WAIT_RESP) begin
        if (!mem.mem_busy)       kill <= 1'b0;
        else if (redirect_valid) kill <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (insn_valid && insn_ready),
    .flush   (redirect_valid),
    .din     ({req_pc, mem.mem_data_out}),
    .dout    ({insn_pc, insn}),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign insn_valid = !fifo_empty;

  a_no_issue_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(issue && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural memory and stream model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] SA = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b1;
  logic [31:0] insn;
  logic [31:0] insn_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; int c; } ev_t;
  ev_t iss_q[$];
  ev_t pop_q[$];

  always #5 clock = ~clock;

  fetch_if mif ();

  fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem            (mif),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h2008_0005;
    if (a == 32'h8002_0004) return 32'h2009_0007;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory answers with the word at the address it is being presented.
  assign mif.mem_data_out = mem_word(mif.mem_address);
  assign mif.mem_busy     = busy;

  // Records issues and accepted instructions just before each rising edge.
  always @(negedge clock) begin
    #4;
    if (reset_n && mif.mem_enable) iss_q.push_back('{mif.mem_address, 32'h0, cyc});
    if (reset_n && insn_valid && insn_ready) pop_q.push_back('{insn_pc, insn, cyc});
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic start_run();
    @(negedge clock);
    reset_n = 1'b1;
    iss_q.delete();
    pop_q.delete();
  endtask

  task automatic wait_issue(input logic [31:0] addr, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      #3;
      if (mif.mem_enable && mif.mem_address == addr) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    busy = 1'b0; insn_ready = 1'b1;
    apply_reset();
    @(negedge clock); #2;
    checks++; if (mif.mem_enable !== 1'b0) begin failures++; $display("FAIL reset_mem_enable got=%b want=0", mif.mem_enable); end
    checks++; if (mif.mem_address !== SA) begin failures++; $display("FAIL reset_mem_address got=%h want=%h", mif.mem_address, SA); end
    checks++; if (mif.mem_rw !== 1'b1) begin failures++; $display("FAIL reset_mem_rw got=%b want=1", mif.mem_rw); end
    checks++; if (mif.mem_access_size !== ACC_1W) begin failures++; $display("FAIL reset_access_size got=%b want=00", mif.mem_access_size); end
    checks++; if (mif.mem_data_in !== 32'h0) begin failures++; $display("FAIL reset_data_in got=%h want=0", mif.mem_data_in); end
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL reset_insn_valid got=%b want=0", insn_valid); end
    checks++; if (insn !== 32'h0) begin failures++; $display("FAIL reset_insn got=%h want=0", insn); end
    checks++; if (insn_pc !== 32'h0) begin failures++; $display("FAIL reset_insn_pc got=%h want=0", insn_pc); end
  endtask

  task automatic test_basic();
    busy = 1'b0; insn_ready = 1'b1;
    apply_reset();
    start_run();
    repeat (12) @(negedge clock);
    #2;
    checks++;
    if (iss_q.size() < 2 || pop_q.size() < 2) begin
      failures++; $display("FAIL basic_counts got iss=%0d pop=%0d want>=2", iss_q.size(), pop_q.size());
    end else begin
      checks++; if (iss_q[0].a !== SA) begin failures++; $display("FAIL basic_issue0 got=%h want=%h", iss_q[0].a, SA); end
      checks++; if (iss_q[1].a !== SA + 4) begin failures++; $display("FAIL basic_issue1 got=%h want=%h", iss_q[1].a, SA + 4); end
      checks++; if (iss_q[1].c - iss_q[0].c != 2) begin failures++; $display("FAIL basic_issue_spacing got=%0d want=2", iss_q[1].c - iss_q[0].c); end
      checks++; if (pop_q[0].c - iss_q[0].c != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", pop_q[0].c - iss_q[0].c); end
      checks++; if (pop_q[0].a !== SA || pop_q[0].d !== 32'h2008_0005) begin failures++; $display("FAIL basic_insn0 got=%h/%h want=%h/20080005", pop_q[0].a, pop_q[0].d, SA); end
      checks++; if (pop_q[1].a !== SA + 4 || pop_q[1].d !== 32'h2009_0007) begin failures++; $display("FAIL basic_insn1 got=%h/%h want=%h/20090007", pop_q[1].a, pop_q[1].d, SA + 4); end
    end
  endtask

  task automatic test_busy();
    busy = 1'b0; insn_ready = 1'b1;
    apply_reset();
    start_run();
    @(negedge clock);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (mif.mem_enable !== 1'b0) begin failures++; $display("FAIL busy_enable[%0d] got=%b want=0", i, mif.mem_enable); end
      checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL busy_insn_valid[%0d] got=%b want=0", i, insn_valid); end
      checks++; if (mif.mem_address !== SA) begin failures++; $display("FAIL busy_hold_addr[%0d] got=%h want=%h", i, mif.mem_address, SA); end
      @(negedge clock);
    end
    busy = 1'b0;
    repeat (6) @(negedge clock);
    #2;
    checks++;
    if (iss_q.size() < 2 || pop_q.size() < 1) begin
      failures++; $display("FAIL busy_counts got iss=%0d pop=%0d", iss_q.size(), pop_q.size());
    end else begin
      checks++; if (pop_q[0].c - iss_q[0].c != 5) begin failures++; $display("FAIL busy_capture_time got=%0d want=5", pop_q[0].c - iss_q[0].c); end
      checks++; if (pop_q[0].d !== 32'h2008_0005) begin failures++; $display("FAIL busy_capture_data got=%h want=20080005", pop_q[0].d); end
      checks++; if (iss_q[1].a !== SA + 4 || iss_q[1].c - iss_q[0].c != 5) begin failures++; $display("FAIL busy_next_issue got=%h@%0d want=%h@5", iss_q[1].a, iss_q[1].c - iss_q[0].c, SA + 4); end
    end
  endtask

  task automatic test_backpressure();
    busy = 1'b0; insn_ready = 1'b0;
    apply_reset();
    start_run();
    repeat (10) @(negedge clock);
    #2;
    checks++; if (iss_q.size() != DEPTH) begin failures++; $display("FAIL bp_issue_count got=%0d want=%0d", iss_q.size(), DEPTH); end
    checks++; if (pop_q.size() != 0) begin failures++; $display("FAIL bp_pop_count got=%0d want=0", pop_q.size()); end
    checks++; if (insn_valid !== 1'b1 || insn_pc !== SA || insn !== 32'h2008_0005) begin failures++; $display("FAIL bp_head_hold got=%b/%h/%h want=1/%h/20080005", insn_valid, insn_pc, insn, SA); end
    @(negedge clock);
    insn_ready = 1'b1;
    repeat (12) @(negedge clock);
    #2;
    checks++;
    if (iss_q.size() < 3 || pop_q.size() < 3) begin
      failures++; $display("FAIL bp_resume_counts got iss=%0d pop=%0d want>=3", iss_q.size(), pop_q.size());
    end else begin
      checks++; if (iss_q[2].a !== SA + 8) begin failures++; $display("FAIL bp_resume_issue got=%h want=%h", iss_q[2].a, SA + 8); end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (pop_q[k].a !== SA + 32'(4 * k) || pop_q[k].d !== mem_word(SA + 32'(4 * k))) begin
          failures++; $display("FAIL bp_drain[%0d] got=%h/%h want=%h/%h", k, pop_q[k].a, pop_q[k].d, SA + 32'(4 * k), mem_word(SA + 32'(4 * k)));
        end
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    busy = 1'b0; insn_ready = 1'b1;
    apply_reset();
    start_run();
    wait_issue(SA + 4, 20, found);
    checks++; if (!found) begin failures++; $display("FAIL redir_wait_04 got=timeout want=issue"); end
    @(negedge clock);
    insn_ready = 1'b0;
    wait_issue(SA + 8, 20, found);
    checks++; if (!found) begin failures++; $display("FAIL redir_wait_08 got=timeout want=issue"); end
    @(negedge clock);
    redirect_valid = 1'b1; redirect_pc = 32'h8002_0013; busy = 1'b1;
    @(negedge clock);
    redirect_valid = 1'b0;
    #2;
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b want=0", insn_valid); end
    checks++; if (mif.mem_enable !== 1'b0 || mif.mem_address !== SA + 8) begin failures++; $display("FAIL redir_inflight got=%b/%h want=0/%h", mif.mem_enable, mif.mem_address, SA + 8); end
    @(negedge clock);
    busy = 1'b0;
    @(negedge clock);
    insn_ready = 1'b1;
    repeat (8) @(negedge clock);
    #2;
    checks++;
    if (iss_q.size() < 4 || pop_q.size() < 2) begin
      failures++; $display("FAIL redir_counts got iss=%0d pop=%0d", iss_q.size(), pop_q.size());
    end else begin
      checks++; if (iss_q[3].a !== 32'h8002_0010) begin failures++; $display("FAIL redir_next_issue got=%h want=80020010", iss_q[3].a); end
      checks++; if (pop_q[0].a !== SA) begin failures++; $display("FAIL redir_pop0 got=%h want=%h", pop_q[0].a, SA); end
      checks++; if (pop_q[1].a !== 32'h8002_0010 || pop_q[1].d !== mem_word(32'h8002_0010)) begin failures++; $display("FAIL redir_pop1 got=%h/%h want=80020010/%h", pop_q[1].a, pop_q[1].d, mem_word(32'h8002_0010)); end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    busy = 1'b0; insn_ready = 1'b0;
    apply_reset();
    start_run();
    wait_issue(SA + 4, 20, found);
    checks++; if (!found) begin failures++; $display("FAIL areset_wait got=timeout want=issue"); end
    @(negedge clock);
    busy = 1'b1;
    #2;
    checks++; if (insn_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b want=1", insn_valid); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (mif.mem_enable !== 1'b0) begin failures++; $display("FAIL areset_enable got=%b want=0", mif.mem_enable); end
    checks++; if (insn_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b want=0", insn_valid); end
    checks++; if (mif.mem_address !== SA) begin failures++; $display("FAIL areset_addr got=%h want=%h", mif.mem_address, SA); end
    @(negedge clock);
    busy = 1'b0; insn_ready = 1'b1;
    start_run();
    repeat (4) @(negedge clock);
    #2;
    checks++;
    if (iss_q.size() < 1 || pop_q.size() < 1) begin
      failures++; $display("FAIL areset_restart_counts got iss=%0d pop=%0d", iss_q.size(), pop_q.size());
    end else begin
      checks++; if (iss_q[0].a !== SA) begin failures++; $display("FAIL areset_first_issue got=%h want=%h", iss_q[0].a, SA); end
      checks++; if (pop_q[0].a !== SA || pop_q[0].d !== 32'h2008_0005) begin failures++; $display("FAIL areset_first_insn got=%h/%h want=%h/20080005", pop_q[0].a, pop_q[0].d, SA); end
    end
  endtask

  task automatic test_wrap();
    busy = 1'b0; insn_ready = 1'b1;
    apply_reset();
    start_run();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #2;
    checks++; if (mif.mem_enable !== 1'b0) begin failures++; $display("FAIL wrap_no_issue_on_redirect got=%b want=0", mif.mem_enable); end
    @(negedge clock);
    redirect_valid = 1'b0;
    repeat (8) @(negedge clock);
    #2;
    checks++;
    if (iss_q.size() < 2 || pop_q.size() < 2) begin
      failures++; $display("FAIL wrap_counts got iss=%0d pop=%0d", iss_q.size(), pop_q.size());
    end else begin
      checks++; if (iss_q[0].a !== 32'hFFFF_FFFC || iss_q[1].a !== 32'h0) begin failures++; $display("FAIL wrap_issue got=%h,%h want=fffffffc,00000000", iss_q[0].a, iss_q[1].a); end
      checks++; if (pop_q[0].a !== 32'hFFFF_FFFC || pop_q[0].d !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_pop0 got=%h/%h", pop_q[0].a, pop_q[0].d); end
      checks++; if (pop_q[1].a !== 32'h0 || pop_q[1].d !== mem_word(32'h0)) begin failures++; $display("FAIL wrap_pop1 got=%h/%h", pop_q[1].a, pop_q[1].d); end
    end
  endtask

  // Model: since the last redirect, issues and accepted instructions each walk
  // pc, pc+4, ... and outstanding work (issued - accepted) never exceeds DEPTH.
  task automatic test_random();
    logic [31:0] exp_iss, exp_pop;
    int issued, popped, total_pops;
    busy = 1'b0; insn_ready = 1'b1;
    apply_reset();
    start_run();
    exp_iss = SA; exp_pop = SA; issued = 0; popped = 0; total_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) @(negedge clock);
      busy = ($urandom_range(0, 2) == 0);
      insn_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 23) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      #2;
      if (redirect_valid) begin
        checks++; if (mif.mem_enable !== 1'b0) begin failures++; $display("FAIL rand_issue_on_redirect cyc=%0d got=%b want=0", i, mif.mem_enable); end
        exp_iss = {redirect_pc[31:2], 2'b00};
        exp_pop = exp_iss;
        issued = 0; popped = 0;
      end else begin
        if (mif.mem_enable === 1'b1) begin
          checks++; if (mif.mem_address !== exp_iss) begin failures++; $display("FAIL rand_issue_addr cyc=%0d got=%h want=%h", i, mif.mem_address, exp_iss); end
          checks++; if (busy || (issued + 1 - popped) > DEPTH) begin failures++; $display("FAIL rand_credit cyc=%0d got outstanding=%0d busy=%b want<=%0d busy=0", i, issued + 1 - popped, busy, DEPTH); end
          exp_iss = exp_iss + 32'd4;
          issued++;
        end
        if (insn_valid === 1'b1 && insn_ready) begin
          checks++; if (insn_pc !== exp_pop || insn !== mem_word(exp_pop)) begin failures++; $display("FAIL rand_insn cyc=%0d got=%h/%h want=%h/%h", i, insn_pc, insn, exp_pop, mem_word(exp_pop)); end
          exp_pop = exp_pop + 32'd4;
          popped++;
          total_pops++;
        end
      end
    end
    @(negedge clock);
    redirect_valid = 1'b0;
    checks++; if (total_pops < 200) begin failures++; $display("FAIL rand_progress got=%0d want>=200", total_pops); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_backpressure();
    test_redirect();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the byte-addressable `memory` block.
- It owns the PC and issues single-word reads to memory (access_size 2'b00, rw=1).
- It captures the big-endian word memory returns and queues {pc, instruction} in a small FIFO for the decode stage.
- Supports branch/jump redirect with a flush of queued and in-flight fetches.

Parameters:
- START_ADDR, 32'h80020000, reset PC; equals memory base address.
- ADDR_WIDTH, 32, address/PC width.
- DATA_WIDTH, 32, instruction width.
- FIFO_DEPTH, 2, output queue entries (power of 2, ≥2).

Ports:
- clock  input  1  rising-edge clock, same as memory.
- reset_n  input  1  reset, asynchronous, active-low.
- mem_address  output  ADDR_WIDTH  read address to memory (= pc).
- mem_data_in  output  DATA_WIDTH  tied to 0 (fetch never writes).
- mem_access_size  output  2  fixed 2'b00 (1 word).
- mem_rw  output  1  fixed 1 (read).
- mem_enable  output  1  read request strobe.
- mem_busy  input  1  memory busy; response not ready while high.
- mem_data_out  input  DATA_WIDTH  read data; byte at lowest address in [31:24].
- redirect_valid  input  1  load new PC, flush.
- redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] ignored (forced 0).
- insn_valid  output  1  FIFO head valid.
- insn_ready  input  1  decode accepts head.
- insn  output  DATA_WIDTH  instruction at FIFO head.
- insn_pc  output  ADDR_WIDTH  PC of head instruction.

Behaviour:
- Reset (async assert, sync deassert in use):
  - pc=START_ADDR, state=ISSUE, FIFO empty, kill=0.
  - Outputs: mem_enable=0, mem_address=START_ADDR, mem_rw=1, mem_access_size=2'b00, mem_data_in=0, insn_valid=0, insn=0, insn_pc=0.
- FSM states: ISSUE, WAIT_RESP.
- ISSUE:
  - mem_enable=1 combinationally iff credit available, !mem_busy and !redirect_valid.
  - Credit available means fifo_count + outstanding < FIFO_DEPTH.
  - On a clock edge with mem_enable=1: record req_pc=pc, pc<=pc+4 (wraps mod 2^32), go to WAIT_RESP.
- WAIT_RESP:
  - mem_enable=0; mem_address holds req_pc.
  - On the first edge where mem_busy=0: push {req_pc, mem_data_out} into the FIFO unless kill=1. Then clear kill and go to ISSUE.
  - While mem_busy=1: hold state; no timeout.
- Latency and throughput:
  - Minimum 2 cycles from issue to insn_valid.
  - Peak throughput is 1 instruction per 2 cycles.
  - Exactly one request is outstanding at a time.
- FIFO:
  - Push and pop in the same cycle are both allowed when non-empty.
  - Pop occurs when insn_valid && insn_ready.
  - When full, no new issue occurs: credit prevents overflow, so a push into a full FIFO is impossible and is flagged by assertion.
  - insn/insn_pc hold their value while insn_valid && !insn_ready.
- Redirect (highest priority), on the edge where redirect_valid=1:
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed, so insn_valid=0 the next cycle.
  - In WAIT_RESP: set kill=1, and the pending response is discarded when it arrives.
  - In ISSUE: no request is issued that cycle.
- Simultaneous events:
  - Redirect + response edge: response discarded, pc redirected, state→ISSUE.
  - Redirect + insn pop: the pop is irrelevant because the FIFO is empty after the edge.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state is cleared immediately; any in-flight memory read is abandoned (its response is ignored because the state is ISSUE with kill irrelevant after reset).
- Misaligned PC is impossible: pc[1:0] is always 0.

Decomposition:
- Package fetch_pkg:
  - START_ADDR.
  - Access-size encodings: ACC_1W=2'b00, ACC_4W=2'b01, ACC_8W=2'b10, ACC_16W=2'b11.
  - Fetch state enum {ISSUE, WAIT_RESP}.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO of {pc, insn}.
  - Ports: push, pop, flush, count, full/empty.
  - Instantiated once.
- PC/FSM/credit logic lives in fetch_unit.

Test Plan:
- Reset, then memory preloaded with 0x20080005 at 0x80020000 and 0x20090007 at 0x80020004, busy=0, insn_ready=1:
  - mem_enable pulses with address 0x80020000 then 0x80020004.
  - insn 0x20080005 appears with insn_pc 0x80020000, followed by insn 0x20090007 with insn_pc 0x80020004.
- mem_busy held high 3 cycles after issue at 0x80020000:
  - FSM stays WAIT_RESP, mem_enable=0, insn_valid=0.
  - Word is captured on the first edge with busy low.
  - The next issue is at 0x80020004.
- insn_ready=0 for 10 cycles:
  - Exactly FIFO_DEPTH=2 requests are issued (0x80020000, 0x80020004), then mem_enable stays 0.
  - Raising insn_ready drains in order and resumes at 0x80020008.
- redirect_valid with redirect_pc=0x80020013 while in WAIT_RESP for 0x80020008:
  - Response discarded, FIFO flushed.
  - Next issued address is 0x80020010, and its word appears with insn_pc 0x80020010.
- reset_n asserted low asynchronously mid-WAIT_RESP:
  - mem_enable=0 and insn_valid=0 immediately, without waiting for a clock edge.
  - After release, the first request is at 0x80020000.
- PC wrap: redirect_pc=0xFFFFFFFC:
  - Issues 0xFFFFFFFC, then 0x00000000.
